// File: rtl/countdown_timer_pkg.sv
// Shared constants for the counter family: default width and FSM state encodings.
package countdown_timer_pkg;

  // Default counter / load-data width in bits.
  localparam int unsigned CntWidthDefault = 5;

  // FSM state encodings, kept as plain constants so legacy users can share them.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with optional auto-reload and a one-cycle terminal-count strobe.
// All outputs are registered; reset is asynchronous and active-low.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = CntWidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;

  // Next-state and datapath: load has priority over counting, so a load on the
  // terminal cycle suppresses the strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    tc_d     = 1'b0;

    if (load) begin
      cnt_d    = data;
      preset_d = data;
      state_d  = (data != '0) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StRun: begin
          if (en) begin
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (reload) begin
                cnt_d = preset_q;
              end else begin
                cnt_d   = '0;
                state_d = StDone;
              end
            end
            // cnt_q == 0 in RUN is unreachable; holding avoids any wrap.
          end
        end
        StIdle, StDone: begin
          // Count holds; en and reload have no effect here.
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Status flags track the upcoming state so they are registered alongside it.
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      preset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the timer.
module tb_countdown_timer;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] data;
  logic         en;
  logic         reload;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         tc;

  int n_vec;
  int n_err;

  // Behavioural model: count value, captured preset, running/finished flags, strobe.
  int m_cnt;
  int m_preset;
  bit m_run;
  bit m_done;
  bit m_tc;

  countdown_timer #(
    .WIDTH(W)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (data),
    .en    (en),
    .reload(reload),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_preset = 0;
    m_run    = 0;
    m_done   = 0;
    m_tc     = 0;
  endtask

  // One rising edge of the timer as described by its rules.
  task automatic model_edge(input bit l, input int d, input bit e, input bit r);
    m_tc = 0;
    if (l) begin
      m_cnt    = d;
      m_preset = d;
      m_run    = (d != 0);
      m_done   = 0;
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (r) begin
          m_cnt = m_preset;
        end else begin
          m_cnt  = 0;
          m_run  = 0;
          m_done = 1;
        end
      end else if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cnt"}, int'(cnt), m_cnt);
    check({tag, ".busy"}, int'(busy), int'(m_run));
    check({tag, ".done"}, int'(done), int'(m_done));
    check({tag, ".tc"}, int'(tc), int'(m_tc));
  endtask

  // Drive inputs, take one clock edge, then compare just after the edge.
  task automatic step(input string tag, input bit l, input int d, input bit e, input bit r);
    load   = l;
    data   = W'(d);
    en     = e;
    reload = r;
    @(posedge clk);
    model_edge(l, d, e, r);
    #1;
    compare_all(tag);
  endtask

  // Pulse reset low between edges and check outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    bit seen;
    n_vec  = 0;
    n_err  = 0;
    load   = 1'b0;
    data   = '0;
    en     = 1'b0;
    reload = 1'b0;
    rst    = 1'b0;
    model_reset();
    #1;
    compare_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset_held");
    @(negedge clk);
    rst = 1'b1;

    // Stays idle after reset until a load, whatever en/reload do.
    for (int i = 0; i < 3; i++) step("post_reset_idle", 0, 0, 1, 1);

    // Plain countdown from 5 to DONE, then hold at 0.
    step("cd5_load", 1, 5, 1, 0);
    for (int i = 0; i < 8; i++) step("cd5_run", 0, 0, 1, 0);

    // Auto-reload from 3.
    step("rl3_load", 1, 3, 1, 1);
    for (int i = 0; i < 10; i++) step("rl3_run", 0, 0, 1, 1);

    // Enable gap delays the terminal count.
    step("gap_load", 1, 4, 1, 0);
    step("gap_dec", 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("gap_hold", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("gap_run", 0, 0, 1, 0);

    // Load on the terminal cycle wins and suppresses the strobe.
    step("ldtc_load", 1, 2, 1, 0);
    step("ldtc_dec", 0, 0, 1, 0);
    step("ldtc_reload", 1, 7, 1, 0);
    for (int i = 0; i < 3; i++) step("ldtc_run", 0, 0, 1, 0);

    // Asynchronous reset mid-count aborts with no strobe.
    step("rst31_load", 1, 31, 1, 0);
    for (int i = 0; i < 10; i++) step("rst31_run", 0, 0, 1, 0);
    async_reset("rst31_abort");
    for (int i = 0; i < 4; i++) step("rst31_after", 0, 0, 1, 1);

    // Zero load goes straight to idle.
    step("zero_load", 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("zero_idle", 0, 0, 1, 1);

    // Maximum load: strobe arrives 31 edges after the load edge.
    step("max_load", 1, 31, 1, 0);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step("max_run", 0, 0, 1, 0);
      lat++;
      if (tc) seen = 1;
    end
    check("max_seen", int'(seen), 1);
    check("max_latency", lat, 31);

    // Random traffic; small load values dominate so counts complete often.
    for (int i = 0; i < 3000; i++) begin
      bit l;
      int d;
      l = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand", l, d, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 5, counter and load-data width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-004 load  input  1  load request; sampled on rising clk.
REQ-005 data  input  WIDTH  start value captured when load=1.
REQ-006 en  input  1  count enable; 0 freezes the count in RUN.
REQ-007 reload  input  1  auto-reload mode, sampled at terminal count.
REQ-008 cnt  output  WIDTH  current count value, registered.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  high while state is DONE.
REQ-011 tc  output  1  terminal-count strobe, exactly one cycle wide.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 load=1 with data!=0, in any state: cnt<=data, preset<=data, state->RUN, tc=0.
REQ-014 load=1 with data==0, in any state: cnt<=0, preset<=0, state->IDLE, tc=0, no strobe.
REQ-015 RUN, en=1, cnt>1: cnt<=cnt-1.
REQ-016 RUN, en=1, cnt==1, reload=0: cnt<=0, state->DONE, tc=1 for one cycle.
REQ-017 RUN, en=1, cnt==1, reload=1: cnt<=preset, state stays RUN, tc=1 for one cycle.
REQ-018 RUN, en=0: cnt, state and preset hold; tc=0.
REQ-019 In IDLE and DONE, cnt SHALL hold, and en and reload SHALL be ignored.
REQ-020 Latency: for a load of N on cycle 0 with en held at 1, tc SHALL be high during cycle N (N rising edges after the load edge).
REQ-021 cnt SHALL never wrap from 0 to 2^WIDTH-1; no decrement occurs when cnt==0.
REQ-022 load asserted in the same cycle as a terminal count: load wins, and tc SHALL be 0 for that cycle.
REQ-023 load while in RUN restarts the count from the new data with no tc.
REQ-024 busy, done and tc SHALL be registered outputs with no combinational path from inputs.
REQ-025 WIDTH=5 maximum load is 31, giving tc 31 cycles after load.

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, force cnt=0, preset=0, state=IDLE, busy=0, done=0, tc=0.
REQ-027 Reset asserted mid-RUN SHALL abort the count; no tc SHALL be issued.
REQ-028 After rst deasserts, the block SHALL stay in IDLE until the first load.

Structure
REQ-029 The WIDTH default and the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared counter package/include used by the counter family.
REQ-030 The block SHALL be a single module with no sub-module; the next-state logic and the registered datapath sit in one file.
REQ-031 The preset register SHALL be internal and not exported.

Verification
REQ-032 Reset, then load data=5 with en=1 and reload=0 -> cnt steps 5,4,3,2,1,0; tc high exactly one cycle, on the edge where cnt becomes 0; done=1 afterwards; cnt holds at 0.
REQ-033 Load 3 with reload=1 and en=1 for 10 cycles -> cnt sequence 3,2,1,3,2,1,3,...; tc pulses every 3 cycles; busy stays 1.
REQ-034 Load 4, then en=0 for 2 cycles after the first decrement -> cnt holds at 3 for 2 cycles; tc is delayed by 2 cycles, arriving in cycle 6.
REQ-035 Load 2 and count to cnt==1, then assert load with data=7 on the terminal cycle -> no tc; cnt=7; state RUN.
REQ-036 Load 31, then pulse rst low asynchronously mid-count -> cnt=0, IDLE, busy=0 and tc=0 immediately; no further activity until the next load.
REQ-037 Load data=0 -> state IDLE, cnt=0, tc never asserts, busy=0 and done=0.
